uart_io_ctrl: RTL and testbench

- Responder side of the core's byte-I/O handshake. The control FSM issues a one-cycle uart_go, with rors=1 for send and rors=0 for receive, then busy-waits on uart_done.
- Send path serializes tx_data onto txd as 8N1.
- Receive path deserializes rxd continuously into an RX FIFO; a receive request pops one byte, presented on rx_data for the register writeback.
- Sits between the core datapath and the board UART pins.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_rx_deser.sv | 95 +++++++++
 rtl/uart_io_ctrl.sv | 115 +++++++++++
 tb/tb_uart_io_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and framing constants for the byte-I/O UART responder.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, TX_START, TX_DATA, TX_STOP, RD_WAIT, DONE} req_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_deser.sv
// Free-running 8N1 deserializer: synchronizes rxd, emits a byte with a one-cycle
// valid, or a one-cycle frame_err when the stop bit is low.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);
  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync;
  logic          rx_s;
  rx_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    sh, sh_n;
  logic          err_wait, err_wait_n;
  logic          valid_n, ferr_n;

  assign rx_s = sync[1];
  assign data = sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b11;
      state     <= R_IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      err_wait  <= 1'b0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], rxd};
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      sh        <= sh_n;
      err_wait  <= err_wait_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt + 1'b1;
    idx_n      = idx;
    sh_n       = sh;
    err_wait_n = err_wait;
    valid_n    = 1'b0;
    ferr_n     = 1'b0;
    case (state)
      R_IDLE: begin
        cnt_n = '0;
        // After a bad stop bit, hold off until the line returns high.
        if (err_wait) begin
          if (rx_s) err_wait_n = 1'b0;
        end else if (rx_s == START_BIT) begin
          state_n = R_START;
        end
      end
      R_START: if (cnt == HALF_M1) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = (rx_s == START_BIT) ? R_DATA : R_IDLE;
      end
      R_DATA: if (cnt == FULL_M1) begin
        cnt_n = '0;
        sh_n  = {rx_s, sh[7:1]};
        idx_n = idx + 1'b1;
        if (idx == 3'(DATA_BITS - 1)) state_n = R_STOP;
      end
      R_STOP: if (cnt == FULL_M1) begin
        cnt_n   = '0;
        state_n = R_IDLE;
        if (rx_s == STOP_BIT) begin
          valid_n = 1'b1;
        end else begin
          ferr_n     = 1'b1;
          err_wait_n = 1'b1;
        end
      end
      default: state_n = R_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_io_ctrl.sv
// Byte-I/O responder: serializes sends onto txd, and answers receive requests
// from an RX FIFO filled by the always-running deserializer.
module uart_io_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_go,
  input  logic       rors,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       uart_done,
  output logic       busy,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_overrun,
  output logic       rx_frame_err
);
  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_rx_deser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data      (rx_byte),
    .valid     (rx_valid),
    .frame_err (rx_ferr)
  );

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // At full, a same-cycle pop frees the slot being written.
  assign push  = rx_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (rx_valid && !push) rx_overrun <= 1'b1;
      if (rx_ferr) rx_frame_err <= 1'b1;
    end
  end

  req_state_t    state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    tx_byte;
  logic          cnt_last;

  assign cnt_last  = (cnt == FULL_M1);
  assign busy      = (state != IDLE);
  assign uart_done = (state == DONE);

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE:     if (uart_go) state_n = rors ? TX_START : RD_WAIT;
      TX_START: if (cnt_last) state_n = TX_DATA;
      TX_DATA:  if (cnt_last && idx == 3'(DATA_BITS - 1)) state_n = TX_STOP;
      TX_STOP:  if (cnt_last) state_n = DONE;
      RD_WAIT: if (!empty) begin
        pop     = 1'b1;
        state_n = DONE;
      end
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      tx_byte <= '0;
      rx_data <= '0;
    end else begin
      state <= state_n;
      cnt   <= ((state inside {TX_START, TX_DATA, TX_STOP}) && !cnt_last) ? cnt + 1'b1 : '0;
      if (state == TX_DATA && cnt_last) idx <= idx + 1'b1;
      if (state == IDLE && uart_go && rors) tx_byte <= tx_data;
      if (pop) rx_data <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_comb begin
    case (state)
      TX_START: txd = START_BIT;
      TX_DATA:  txd = tx_byte[idx];
      default:  txd = STOP_BIT;
    endcase
  end
endmodule

// File: tb/tb_uart_io_ctrl.sv
// Scoreboard bench for uart_io_ctrl: stimulus queues expected completions and
// txd frames; monitors decode txd and watch uart_done independently.
module tb_uart_io_ctrl;
  localparam int CPB = 4;
  localparam int FD  = 4;

  logic       clk = 1'b0;
  logic       rst, uart_go, rors, rxd;
  logic [7:0] tx_data, rx_data;
  logic       uart_done, busy, txd, rx_overrun, rx_frame_err;

  uart_io_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .uart_go(uart_go), .rors(rors), .tx_data(tx_data),
    .rx_data(rx_data), .uart_done(uart_done), .busy(busy), .txd(txd),
    .rxd(rxd), .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  typedef struct {
    bit         is_tx;
    logic [7:0] data;
    int         go_cyc;
  } exp_t;

  exp_t       done_q[$];
  logic [9:0] frame_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // txd decoder: samples each bit at its centre, aborts on reset.
  bit         tm_act = 1'b0;
  int         tm_cnt = 0;
  logic [9:0] tm_frm;
  always @(negedge clk) begin
    if (rst) tm_act = 1'b0;
    else if (!tm_act) begin
      if (txd === 1'b0) begin
        tm_act = 1'b1;
        tm_cnt = 0;
      end
    end else tm_cnt++;
    if (tm_act && (tm_cnt % CPB) == CPB / 2) begin
      tm_frm[tm_cnt / CPB] = txd;
      if (tm_cnt / CPB == 9) begin
        tm_act = 1'b0;
        if (frame_q.size() == 0) fail("tx_unexpected_frame");
        else chk("tx_frame", {22'd0, tm_frm}, {22'd0, frame_q.pop_front()});
      end
    end
  end

  // Completion monitor.
  bit         rp = 1'b0;
  logic [7:0] rp_val;
  always @(negedge clk) begin
    exp_t e;
    if (rp) begin
      chk("rx_data_after_done", {24'd0, rx_data}, {24'd0, rp_val});
      rp = 1'b0;
    end
    if (uart_done === 1'b1) begin
      if (done_q.size() == 0) fail("unexpected_done");
      else begin
        e = done_q.pop_front();
        if (e.is_tx) chk("tx_latency", cyc - e.go_cyc, 10 * CPB + 1);
        else begin
          chk("rx_data_at_done", {24'd0, rx_data}, {24'd0, e.data});
          rp     = 1'b1;
          rp_val = e.data;
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(bit r, logic [7:0] d, bit expect_done);
    exp_t e;
    uart_go = 1'b1;
    rors    = r;
    tx_data = d;
    if (expect_done) begin
      e.is_tx  = r;
      e.data   = d;
      e.go_cyc = cyc;
      done_q.push_back(e);
      if (r) frame_q.push_back({1'b1, d, 1'b0});
    end
    tick();
    uart_go = 1'b0;
  endtask

  task automatic wait_idle(string name, int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) fail({name, "_timeout"});
  endtask

  task automatic rx_frame(logic [7:0] d, logic stopb);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(CPB);
    end
    rxd = stopb;
    tick(CPB);
    rxd = 1'b1;
    tick(CPB);
  endtask

  initial begin
    rst = 1'b1; uart_go = 1'b0; rors = 1'b0; tx_data = '0; rxd = 1'b1;
    tick(3);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", uart_done, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_frame_err", rx_frame_err, 0);
    rst = 1'b0;
    tick(2);

    issue(1'b1, 8'hA5, 1'b1);
    chk("busy_during_send", busy, 1);
    tick(20);
    chk("busy_mid_send", busy, 1);
    wait_idle("send_a5", 60);

    issue(1'b0, 8'h3C, 1'b1);
    tick(8);
    chk("busy_rd_wait_empty", busy, 1);
    rx_frame(8'h3C, 1'b1);
    wait_idle("recv_3c", 20);
    tick(20);
    chk("rx_data_holds", rx_data, 8'h3C);
    chk("overrun_clear", rx_overrun, 0);

    for (int i = 1; i <= 5; i++) rx_frame(8'(i), 1'b1);
    chk("overrun_set", rx_overrun, 1);
    for (int i = 1; i <= 4; i++) begin
      issue(1'b0, 8'(i), 1'b1);
      wait_idle("recv_fifo", 10);
    end
    issue(1'b0, 8'h77, 1'b1);
    tick(6);
    chk("fifth_recv_waits", busy, 1);

    rx_frame(8'h55, 1'b0);
    chk("frame_err_set", rx_frame_err, 1);
    chk("bad_frame_not_pushed", busy, 1);
    rx_frame(8'h77, 1'b1);
    wait_idle("recv_77", 20);

    rxd = 1'b0;
    tick(1);
    rxd = 1'b1;
    tick(10);
    issue(1'b0, 8'h5A, 1'b1);
    tick(4);
    chk("glitch_not_pushed", busy, 1);
    rx_frame(8'h5A, 1'b1);
    wait_idle("recv_5a", 20);

    issue(1'b1, 8'h33, 1'b0);
    tick(14);
    rst = 1'b1;
    tick(1);
    chk("txd_after_rst", txd, 1);
    chk("busy_after_rst", busy, 0);
    chk("overrun_cleared_by_rst", rx_overrun, 0);
    chk("frame_err_cleared_by_rst", rx_frame_err, 0);
    rst = 1'b0;
    tick(5);
    issue(1'b1, 8'h00, 1'b1);
    wait_idle("send_00", 60);

    tick(10);
    chk("done_q_drained", done_q.size(), 0);
    chk("tx_frames_drained", frame_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
